lag2_diff_sched: RTL and testbench
==================================

LAG2_DIFF_SCHED -- requirements
Module: lag2_diff_sched

Interface
REQ-001 Parameter N_REQ, default 4; number of requesters, fixed at 4 in this revision.
REQ-002 Parameter WIDTH, default 8; bits per job word.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req  input  N_REQ  per-requester job request, level, held until granted.
REQ-006 req_data  input  N_REQ*WIDTH  lane i job word at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-007 gnt  output  N_REQ  one-hot grant pulse, one cycle; lane data captured in that cycle.
REQ-008 busy  output  1  high from the grant cycle through the DONE cycle inclusive.
REQ-009 bit_valid  output  1  high during each SHIFT cycle.
REQ-010 bit_out  output  1  current serialized bit, LSB first; 0 when bit_valid is low.
REQ-011 diff_out  output  1  current bit differs from the bit two positions earlier in the same job.
REQ-012 done  output  1  one-cycle pulse marking job completion.
REQ-013 done_id  output  2  index of the completed requester; registered, held until next done.
REQ-014 diff_cnt  output  3  count of diff_out pulses in the completed job (0..WIDTH-2); registered, held until next done.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-016 IDLE with req==0: stay in IDLE; all pulse outputs low.
REQ-017 IDLE with any req bit set: select a winner round-robin starting from pointer ptr; the lowest index >= ptr wins, wrapping modulo N_REQ.
REQ-018 Grant cycle: gnt[winner]=1 combinationally; at the clock edge the block latches the lane word into the shift register and the winner into the id register, clears the bit index, history and counter, and enters SHIFT.
REQ-019 ptr SHALL update to (winner+1) mod N_REQ at the grant edge.
REQ-020 SHIFT lasts exactly WIDTH cycles; cycle k (k=0..WIDTH-1) drives bit_out = word[k] and bit_valid=1.
REQ-021 diff_out SHALL be 0 for k=0 and k=1, and equal word[k] XOR word[k-2] for k>=2; no carry-over of history between jobs.
REQ-022 The counter increments on every cycle with diff_out=1; the width is fixed, so the count never wraps (max WIDTH-2=6).
REQ-023 After SHIFT cycle k=WIDTH-1: enter DONE; in DONE, done=1, diff_cnt and done_id update to the new values at the entry edge; return to IDLE at the next edge.
REQ-024 Latency: grant in cycle t, bits in cycles t+1..t+WIDTH, done in t+WIDTH+1, earliest next grant in t+WIDTH+2.
REQ-025 Requests seen during SHIFT or DONE are ignored until IDLE; a req dropped before grant is never serviced.
REQ-026 A requester whose req is still high after its own done SHALL be treated as a new job.

Reset
REQ-027 When reset=1 at an edge: state=IDLE, ptr=0, counter=0, history=0, diff_cnt=0, done_id=0; gnt, busy, bit_valid, bit_out, diff_out and done are all 0 in the following cycle.
REQ-028 A reset during SHIFT or DONE SHALL abort the job with no done pulse; reset has priority over every transition.

Structure
REQ-029 Shared package lag2_sched_pkg SHALL hold N_REQ, WIDTH, the count width and the IDLE/SHIFT/DONE state encoding.
REQ-030 The lag-2 compare SHALL be a sub-module lag2_diff_core (clk, reset, clr, in, valid -> diff), holding a two-bit history and a warm-up count.
REQ-031 Arbiter, shift register and FSM SHALL reside in lag2_diff_sched; expected size 150-250 lines.

Verification
REQ-032 Single request: req=4'b0001, lane0=8'b1100_1100 -> gnt=0001 for one cycle; bits 0,0,1,1,0,0,1,1; diff_out 0,0,1,1,1,1,1,1; done at t+9 with diff_cnt=6, done_id=0.
REQ-033 Patterns on lane2 -> 8'h00 gives diff_cnt=0; 8'h55 gives 0; 8'hF0 gives 2 (diff at k=4,5).
REQ-034 Round-robin: req=4'b1111 held continuously -> grants 0,1,2,3,0 in order, 10 cycles apart.
REQ-035 Wrap: ptr=3 after a grant to lane 2, req=4'b0011 -> lane 0 granted, then lane 1.
REQ-036 Reset at SHIFT k=4 -> no done; next cycle all outputs 0; after release, req=4'b0010 -> lane 1 granted (ptr reset to 0).
REQ-037 Mid-job request: lane 3 raises req during lane 0 SHIFT -> no gnt until IDLE; lane 3 granted at t+10; lane 0 diff_cnt held until lane 3 done.

Source files
------------

// File: rtl/lag2_sched_pkg.sv
// lag2_sched_pkg: shared sizes and FSM state encoding for the lag-2 diff scheduler
package lag2_sched_pkg;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam int ID_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/lag2_diff_core.sv
// lag2_diff_core: flags in != bit two valid cycles earlier (clk, reset, clr, in, valid -> diff)
module lag2_diff_core (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in,
  input  logic valid,
  output logic diff
);
  logic [1:0] hist;
  logic [1:0] warm;
  assign diff = valid && warm == 2'd2 && (in ^ hist[1]);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist <= '0;
      warm <= '0;
    end else if (valid) begin
      hist <= {hist[0], in};
      warm <= warm == 2'd2 ? warm : warm + 2'd1;
    end
  end
endmodule

// File: rtl/lag2_diff_sched.sv
// lag2_diff_sched: round-robin job arbiter, LSB-first serializer with lag-2 diff count (req/req_data in; gnt, busy, bit_valid, bit_out, diff_out, done, done_id, diff_cnt out)
module lag2_diff_sched
  import lag2_sched_pkg::*;
#(
  parameter int N_REQ = lag2_sched_pkg::N_REQ,
  parameter int WIDTH = lag2_sched_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   bit_valid,
  output logic                   bit_out,
  output logic                   diff_out,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       diff_cnt
);
  localparam int KW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, win, id;
  logic [WIDTH-1:0] sreg;
  logic [KW-1:0] k;
  logic [CNT_W-1:0] cnt;
  logic grant, diff, last;
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) win = ID_W'((int'(ptr) + i) % N_REQ);
  end
  assign grant = state == IDLE && |req && !reset;
  assign last = k == KW'(WIDTH - 1);
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE  ? (grant ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  always_comb begin
    gnt = grant ? N_REQ'(1) << win : '0;
    busy = grant || state != IDLE;
    bit_valid = state == SHIFT;
    bit_out = bit_valid & sreg[0];
    diff_out = diff;
    done = state == DONE && !reset;
  end
  lag2_diff_core u_core (
    .clk(clk),
    .reset(reset),
    .clr(grant),
    .in(sreg[0]),
    .valid(bit_valid),
    .diff(diff)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      id <= '0;
      sreg <= '0;
      k <= '0;
      cnt <= '0;
      diff_cnt <= '0;
      done_id <= '0;
    end else if (grant) begin
      ptr <= ID_W'((int'(win) + 1) % N_REQ);
      id <= win;
      sreg <= req_data[WIDTH*win +: WIDTH];
      k <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sreg <= sreg >> 1;
      k <= k + KW'(1);
      cnt <= cnt + CNT_W'(diff);
      if (last) begin
        diff_cnt <= cnt + CNT_W'(diff);
        done_id <= id;
      end
    end
  end
endmodule

// File: tb/tb_lag2_diff_sched.sv
// tb_lag2_diff_sched: randomized self-checking bench against a job-level reference model
module tb_lag2_diff_sched;
  logic clk = 0, reset = 1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] gnt;
  logic busy, bit_valid, bit_out, diff_out, done;
  logic [1:0] done_id;
  logic [2:0] diff_cnt;
  int checks = 0, passed = 0, cyc = 0, ptr_m = 0;
  logic [2:0] held_cnt = '0;
  logic [1:0] held_id = '0;
  lag2_diff_sched dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
    .bit_valid(bit_valid), .bit_out(bit_out), .diff_out(diff_out), .done(done),
    .done_id(done_id), .diff_cnt(diff_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    return 0;
  endfunction
  function automatic logic [13:0] outs();
    return {gnt, busy, bit_valid, bit_out, diff_out, done, diff_cnt, done_id};
  endfunction
  task automatic do_job(input logic [3:0] r, input logic [31:0] d, input bit hold,
                        input logic [3:0] late, output int gc, output int w);
    logic [7:0] word;
    logic [3:0] eg;
    logic [13:0] exp_v;
    logic e_d;
    int n;
    req = r;
    req_data = d;
    #1;
    w = pick(r);
    word = d[8*w +: 8];
    eg = 4'b1 << w;
    gc = cyc;
    exp_v = {eg, 1'b1, 4'b0, held_cnt, held_id};
    checks++;
    if (outs() !== exp_v) $display("FAIL grant lane=%0d got %b exp %b", w, outs(), exp_v);
    else passed++;
    ptr_m = (w + 1) % 4;
    n = 0;
    tick;
    if (!hold) req[w] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e_d = k >= 2 && (word[k] ^ word[k-2]);
      exp_v = {4'b0, 1'b1, 1'b1, word[k], e_d, 1'b0, held_cnt, held_id};
      checks++;
      if (outs() !== exp_v) $display("FAIL shift k=%0d got %b exp %b", k, outs(), exp_v);
      else passed++;
      n += int'(e_d);
      if (k == 2) req = req | late;
      tick;
    end
    exp_v = {4'b0, 1'b1, 3'b0, 1'b1, 3'(n), 2'(w)};
    checks++;
    if (outs() !== exp_v) $display("FAIL done got %b exp %b", outs(), exp_v);
    else passed++;
    held_cnt = 3'(n);
    held_id = 2'(w);
    tick;
  endtask
  task automatic test_reset;
    reset = 1;
    req = '0;
    tick;
    tick;
    checks++;
    if (outs() !== 14'b0) $display("FAIL reset_state got %b exp 0", outs());
    else passed++;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (outs() !== 14'b0) $display("FAIL idle_no_req got %b exp 0", outs());
      else passed++;
    end
    ptr_m = 0;
    held_cnt = '0;
    held_id = '0;
  endtask
  task automatic test_single;
    int gc, w;
    do_job(4'b0001, 32'h0000_00CC, 0, 4'b0, gc, w);
    checks++;
    if ({diff_cnt, done_id} !== {3'd6, 2'd0}) $display("FAIL single got cnt=%0d id=%0d exp cnt=6 id=0", diff_cnt, done_id);
    else passed++;
  endtask
  task automatic test_patterns;
    logic [7:0] pats [3] = '{8'h00, 8'h55, 8'hF0};
    logic [2:0] exps [3] = '{3'd0, 3'd0, 3'd2};
    int gc, w;
    for (int i = 0; i < 3; i++) begin
      do_job(4'b0100, {8'h00, pats[i], 16'h0000}, 0, 4'b0, gc, w);
      checks++;
      if (diff_cnt !== exps[i]) $display("FAIL pattern %h got %0d exp %0d", pats[i], diff_cnt, exps[i]);
      else passed++;
    end
  endtask
  task automatic test_wrap;
    int gc, w;
    do_job(4'b0011, $urandom, 0, 4'b0, gc, w);
    checks++;
    if (done_id !== 2'd0) $display("FAIL wrap_first got %0d exp 0", done_id);
    else passed++;
    do_job(req, $urandom, 0, 4'b0, gc, w);
    checks++;
    if (done_id !== 2'd1) $display("FAIL wrap_second got %0d exp 1", done_id);
    else passed++;
  endtask
  task automatic test_round_robin;
    int gc, w, prev;
    reset = 1;
    tick;
    reset = 0;
    ptr_m = 0;
    held_cnt = '0;
    held_id = '0;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      do_job(4'b1111, $urandom, 1, 4'b0, gc, w);
      checks++;
      if (done_id !== 2'(i % 4)) $display("FAIL rr_order i=%0d got %0d exp %0d", i, done_id, i % 4);
      else passed++;
      if (i > 0) begin
        checks++;
        if (gc - prev !== 10) $display("FAIL rr_spacing got %0d exp 10", gc - prev);
        else passed++;
      end
      prev = gc;
    end
    req = '0;
  endtask
  task automatic test_mid_job;
    int gc0, gc1, w;
    do_job(4'b0001, $urandom, 0, 4'b1000, gc0, w);
    do_job(req, $urandom, 0, 4'b0, gc1, w);
    checks++;
    if (gc1 - gc0 !== 10 || done_id !== 2'd3) $display("FAIL mid_job got gap=%0d id=%0d exp gap=10 id=3", gc1 - gc0, done_id);
    else passed++;
  endtask
  task automatic test_abort;
    int gc, w;
    req = 4'b0001;
    req_data = $urandom;
    #1;
    checks++;
    if (gnt !== 4'b0001) $display("FAIL abort_grant got %b exp 0001", gnt);
    else passed++;
    tick;
    req = '0;
    repeat (4) tick;
    reset = 1;
    tick;
    checks++;
    if (outs() !== 14'b0) $display("FAIL abort_reset got %b exp 0", outs());
    else passed++;
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++;
      if ({done, busy} !== 2'b00) $display("FAIL abort_no_done cyc=%0d got %b exp 00", i, {done, busy});
      else passed++;
    end
    ptr_m = 0;
    held_cnt = '0;
    held_id = '0;
    do_job(4'b0010, $urandom, 0, 4'b0, gc, w);
    checks++;
    if (done_id !== 2'd1) $display("FAIL abort_ptr got %0d exp 1", done_id);
    else passed++;
  endtask
  task automatic test_random;
    int gc, w;
    for (int i = 0; i < 20; i++) do_job(4'($urandom_range(1, 15)), $urandom, 0, 4'b0, gc, w);
    req = '0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_patterns;
    test_wrap;
    test_round_robin;
    test_mid_job;
    test_abort;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
